// File: rtl/dcache_burst_collector.sv
// Avalon-MM burst read engine for the dcache miss/uncached path: one burst of 1-3 dwords
// is gathered into a 96-bit little-endian buffer. Optional watchdog: DCACHE_BURST_TIMEOUT_EN.
module dcache_burst_collector #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [29:0] address,
    input  logic [1:0]  dword_length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [95:0] read_data,
    output logic [29:0] avm_address,
    output logic        avm_read,
    output logic [3:0]  avm_burstcount,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata
);

    // Handshake: the command transfers on any cycle with avm_read=1 and avm_waitrequest=0;
    // a beat transfers on any cycle with avm_readdatavalid=1 (no backpressure on read data).

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  len;
    logic [1:0]  len_in;
    logic [1:0]  beat_cnt;
    logic        accept;
    logic        beat;
    logic        last_beat;
    logic        timeout;
    logic        done_q;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // A zero length request still fetches one dword.
    assign len_in    = (dword_length == 2'd0) ? 2'd1 : dword_length;
    assign accept    = (state == REQ) && !avm_waitrequest;
    assign beat      = avm_readdatavalid && (state != IDLE);
    assign last_beat = beat && (beat_cnt == len - 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (last_beat || timeout) begin
                    state_next = IDLE;
                end else if (accept) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (last_beat || timeout) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        avm_read = 1'b0;
        busy     = 1'b0;
        done     = done_q;
        case (state)
            REQ: begin
                avm_read = 1'b1;
                busy     = 1'b1;
            end
            DATA: begin
                busy = 1'b1;
            end
            default: begin
                avm_read = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Command registers and capture buffer only change on an accepted start or a live beat,
    // so read_data holds from done until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avm_address    <= '0;
            avm_burstcount <= '0;
            len            <= 2'd1;
            beat_cnt       <= '0;
            read_data      <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= last_beat;
            if (state == IDLE) begin
                if (start) begin
                    avm_address    <= address;
                    avm_burstcount <= {2'b00, len_in};
                    len            <= len_in;
                    beat_cnt       <= '0;
                    read_data      <= '0;
                end
            end else if (beat) begin
                case (beat_cnt)
                    2'd0:    read_data[31:0]  <= avm_readdata;
                    2'd1:    read_data[63:32] <= avm_readdata;
                    default: read_data[95:64] <= avm_readdata;
                endcase
                beat_cnt <= beat_cnt + 2'd1;
            end
        end
    end

`ifdef DCACHE_BURST_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            error_q;

    // Idle cycles are counted while busy; any accepted command or beat restarts the count.
    assign timeout = (state != IDLE) && !accept && !beat && (wd_cnt == WD_LAST);
    assign error   = error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= timeout;
            if (state == IDLE || accept || beat || timeout) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_burst_collector.sv
// Directed bench for dcache_burst_collector: stimulus pushes expected commands and buffers,
// a negedge monitor pops and compares them when the DUT accepts a command or pulses done.
module tb_dcache_burst_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [29:0] address;
    logic [1:0]  dword_length;
    logic        busy;
    logic        done;
    logic        error;
    logic [95:0] read_data;
    logic [29:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_burstcount;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;

    logic [95:0] exp_q[$];
    logic [33:0] cmd_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_count = 0;
    int          error_count = 0;
    int          read_cycles = 0;

    dcache_burst_collector #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .address           (address),
        .dword_length      (dword_length),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .read_data         (read_data),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (avm_read) read_cycles++;
                if (avm_read && !avm_waitrequest) begin
                    if (cmd_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL cmd_unexpected: got %0h expected none", {avm_address, avm_burstcount});
                    end else begin
                        check("cmd", {avm_address, avm_burstcount}, cmd_q.pop_front());
                    end
                end
                if (done) begin
                    done_count++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL done_unexpected: got %0h expected none", read_data);
                    end else begin
                        check("read_data", read_data, exp_q.pop_front());
                    end
                end
                if (error) error_count++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // called at posedge+1; returns at posedge+1 of the first REQ cycle
    task automatic cmd_start(input logic [29:0] a, input logic [1:0] l);
        start        = 1'b1;
        address      = a;
        dword_length = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic accept_cmd(input int nwait);
        avm_waitrequest = (nwait > 0);
        repeat (nwait) begin
            @(posedge clk);
            #1;
        end
        avm_waitrequest = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap);
        avm_readdatavalid = 1'b1;
        avm_readdata      = d;
        @(posedge clk);
        #1;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_count < target && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("done_count", done_count, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rc0;
        int dc0;
        int ec0;
        int seen;

        rst               = 1'b1;
        start             = 1'b0;
        address           = '0;
        dword_length      = '0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_avm_read", avm_read, 0);
        check("rst_avm_address", avm_address, 0);
        check("rst_burstcount", avm_burstcount, 0);
        check("rst_read_data", read_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // 1: single dword, no stalls
        cmd_start(30'h40, 2'd1);
        cmd_q.push_back({30'h40, 4'd1});
        exp_q.push_back(96'h0000_0000_0000_0000_DEADBEEF);
        accept_cmd(0);
        send_beat(32'hDEADBEEF, 0);
        wait_done(1);
        idle(3);
        check("t1_single_done", done_count, 1);

        // 2: three dwords, 4 wait states, gapped beats
        rc0 = read_cycles;
        cmd_start(30'h1234, 2'd3);
        cmd_q.push_back({30'h1234, 4'd3});
        exp_q.push_back(96'h33333333_22222222_11111111);
        accept_cmd(4);
        send_beat(32'h11111111, 1);
        send_beat(32'h22222222, 1);
        send_beat(32'h33333333, 1);
        wait_done(2);
        idle(3);
        check("t2_read_cycles", read_cycles - rc0, 5);
        check("t2_single_done", done_count, 2);
        check("t2_busy_after", busy, 0);

        // 3: zero length treated as one; start while busy ignored
        rc0 = read_cycles;
        cmd_start(30'h123, 2'd0);
        cmd_q.push_back({30'h123, 4'd1});
        exp_q.push_back(96'h0000_0000_0000_0000_CAFEF00D);
        accept_cmd(0);
        cmd_start(30'h3FF, 2'd3);
        @(negedge clk);
        check("t3_busy", busy, 1);
        check("t3_addr_hold", avm_address, 30'h123);
        @(posedge clk);
        #1;
        send_beat(32'hCAFEF00D, 0);
        wait_done(3);
        idle(4);
        check("t3_read_cycles", read_cycles - rc0, 1);
        check("t3_burstcount", avm_burstcount, 1);

        // 4: reset after first beat of a 3-beat burst
        dc0 = done_count;
        cmd_start(30'h200, 2'd3);
        cmd_q.push_back({30'h200, 4'd3});
        accept_cmd(0);
        send_beat(32'hAAAA0001, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_avm_read", avm_read, 0);
        check("t4_avm_address", avm_address, 0);
        check("t4_burstcount", avm_burstcount, 0);
        check("t4_read_data", read_data, 0);
        check("t4_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_beat(32'hAAAA0002, 0);
        send_beat(32'hAAAA0003, 0);
        idle(2);
        check("t4_stray_read_data", read_data, 0);
        check("t4_no_done", done_count, dc0);
        cmd_start(30'h300, 2'd2);
        cmd_q.push_back({30'h300, 4'd2});
        exp_q.push_back(96'h00000000_BBBB0002_BBBB0001);
        accept_cmd(0);
        send_beat(32'hBBBB0001, 0);
        send_beat(32'hBBBB0002, 0);
        wait_done(dc0 + 1);
        idle(2);

        // 5: start in the done cycle
        rc0 = read_cycles;
        dc0 = done_count;
        cmd_start(30'h400, 2'd1);
        cmd_q.push_back({30'h400, 4'd1});
        cmd_q.push_back({30'h500, 4'd2});
        exp_q.push_back(96'h0000_0000_0000_0000_5A5A5A5A);
        exp_q.push_back(96'h00000000_0B0B0002_0B0B0001);
        accept_cmd(0);
        send_beat(32'h5A5A5A5A, 0);
        start        = 1'b1;
        address      = 30'h500;
        dword_length = 2'd2;
        @(negedge clk);
        check("t5_done_cycle", done, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t5_cleared", read_data, 0);
        check("t5_second_read", avm_read, 1);
        accept_cmd(0);
        send_beat(32'h0B0B0001, 0);
        send_beat(32'h0B0B0002, 0);
        wait_done(dc0 + 2);
        idle(3);
        check("t5_read_cycles", read_cycles - rc0, 2);

        // 6: slave never returns data
        dc0 = done_count;
        ec0 = error_count;
        cmd_start(30'h55, 2'd2);
        cmd_q.push_back({30'h55, 4'd2});
        accept_cmd(0);
        seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (error && seen == 0) seen = n;
        end
`ifdef DCACHE_BURST_TIMEOUT_EN
        check("t6_error_cycle", seen, 17);
        check("t6_error_pulses", error_count - ec0, 1);
        check("t6_busy", busy, 0);
`else
        check("t6_error_cycle", seen, 0);
        check("t6_error_pulses", error_count - ec0, 0);
        check("t6_busy_hung", busy, 1);
`endif
        check("t6_no_done", done_count, dc0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        check("exp_q_empty", exp_q.size(), 0);
        check("cmd_q_empty", cmd_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // watchdog on the whole run
    initial begin
        #200000;
        $display("FAIL run_timeout: got no end expected end of stimulus");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/dcache_burst_collector.md
Name: dcache_burst_collector

Overview:
Avalon-MM burst read engine for the data cache uncached/miss path.
- Takes a dword-aligned start address and a burst dword count of 1–3, computed by the dcache read-alignment logic.
- Issues one burst read and collects the returned dwords into a 96-bit little-endian buffer.
- The downstream alignment logic extracts the requested bytes from this buffer.

Parameters:
TIMEOUT_CYCLES, 255, watchdog limit in clk cycles without a beat; used only when DCACHE_BURST_TIMEOUT_EN is defined.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  request strobe; accepted only in IDLE
address  input  30  dword address, byte address [31:2]
dword_length  input  2  dwords to fetch; 1..3, 0 is treated as 1
busy  output  1  high from acceptance until done/error
done  output  1  one-cycle pulse when all beats have been collected
error  output  1  one-cycle pulse on watchdog abort; tied 0 without the macro
read_data  output  96  collected dwords; beat i at [32*i+31:32*i]
avm_address  output  30  burst start dword address
avm_read  output  1  read command
avm_burstcount  output  4  beats requested
avm_waitrequest  input  1  slave stall
avm_readdatavalid  input  1  beat valid
avm_readdata  input  32  beat data

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, error, avm_read = 0; avm_address, avm_burstcount, read_data, beat counter = 0.
- States: IDLE, REQ, DATA.
- IDLE, start=1:
  - latch address into avm_address;
  - avm_burstcount = {2'b0, len}, where len = (dword_length==0) ? 1 : dword_length;
  - clear read_data to 0, clear beat counter, set busy;
  - next cycle: REQ with avm_read=1.
- start while busy is ignored. No queueing.
- REQ: avm_read, avm_address, avm_burstcount held stable while avm_waitrequest=1.
  - Command is accepted on the first cycle with avm_read=1 and avm_waitrequest=0.
  - Next state is DATA with avm_read=0.
- Beat capture (REQ or DATA): each cycle with avm_readdatavalid=1 writes avm_readdata into slot [beat counter], then increments the counter (2-bit).
- When the captured beat is the last one (counter==len-1):
  - next cycle done=1, busy=0, state IDLE;
  - a beat arriving in the same cycle as command acceptance with len=1 completes immediately.
- Latency with no stalls and first-cycle data: done asserts 2 cycles after the avm_read acceptance cycle plus (len-1).
- read_data is stable from done until the next accepted start. Unfilled upper dwords read 0.
- avm_readdatavalid in IDLE is ignored. Stray or excess beats never corrupt read_data.
- Back-to-back: start may be asserted in the same cycle done pulses. The FSM is IDLE then, so start is accepted and read_data clears on the following edge.
- Reset mid-burst: immediate return to IDLE. Beats still in flight afterwards are ignored, since they arrive in IDLE.

Optional Feature:
DCACHE_BURST_TIMEOUT_EN
- Defined:
  - an 8-bit+ watchdog counts cycles in REQ/DATA since the last accepted command or beat;
  - on reaching TIMEOUT_CYCLES: error pulses for 1 cycle, avm_read drops, busy=0, state IDLE, done not pulsed;
  - read_data keeps the partial beats.
- Not defined: no counter logic; error constant 0; a slave that never responds hangs the FSM in DATA.

Test Plan:
1. start, address=0x0000_0040, dword_length=1; waitrequest=0; one beat 0xDEADBEEF -> avm_address=0x40, burstcount=1, done 1 cycle, read_data=0x0000_0000_0000_0000_DEADBEEF.
2. dword_length=3; waitrequest high 4 cycles; beats 0x11111111, 0x22222222, 0x33333333 with 1-cycle gaps -> avm_read held 5 cycles, read_data=0x33333333_22222222_11111111, single done.
3. dword_length=0 -> burstcount=1, done after one beat. start pulsed while busy -> ignored, no second avm_read.
4. rst asserted after beat 1 of a 3-beat burst -> all outputs 0 immediately; remaining two beats ignored; a subsequent burst of len 2 returns correct data.
5. start in the done cycle of a previous burst -> second avm_read issued, read_data cleared, new data correct.
6. With DCACHE_BURST_TIMEOUT_EN, TIMEOUT_CYCLES=16, no readdatavalid -> error pulse after 16 cycles, busy=0, done never asserts. Without the macro -> error stays 0.
